// File: rtl/nand_flash_responder.sv
// Device-side NAND flash model: decodes CLE/ALE/WEN/REN strobes and runs reset,
// page read, page program and block erase against an internal byte array.
module nand_flash_responder #(
  parameter int unsigned PAGE_BITS = 9,
  parameter int unsigned T_R       = 16,
  parameter int unsigned T_PROG    = 600,
  parameter int unsigned T_ERASE   = 2100,
  parameter int unsigned T_RST     = 8
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] F_IO,
  input  logic       F_CLE,
  input  logic       F_ALE,
  input  logic       F_WEN,
  input  logic       F_REN,
  output logic       F_RB
);

  localparam int unsigned COL_W       = 9;
  localparam int unsigned ADDR_W      = PAGE_BITS + COL_W;
  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam int unsigned PAGE_BYTES  = 512;
  localparam int unsigned BLOCK_BYTES = 2048;
  localparam int unsigned IDX_W       = 12;
  localparam int unsigned T_MAX_A     = (T_ERASE > T_PROG) ? T_ERASE : T_PROG;
  localparam int unsigned T_MAX_B     = (T_R > T_RST) ? T_R : T_RST;
  localparam int unsigned T_MAX       = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W       = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_ADDR, S_RD_BUSY, S_RD_DATA, S_PG_ADDR, S_PG_DATA,
    S_PG_BUSY, S_ER_ADDR, S_ER_CONF, S_ER_BUSY, S_RST_BUSY
  } state_t;

  state_t               r_state, w_state_nx;
  logic                 r_wen_q, r_ren_q, r_cle_q, r_ale_q;
  logic [7:0]           r_io_q;
  logic                 r_half, w_half_nx;
  logic [COL_W-1:0]     r_col, w_col_nx;
  logic                 r_col_ovf, w_col_ovf_nx;
  logic [PAGE_BITS-1:0] r_page, w_page_nx;
  logic [1:0]           r_acnt, w_acnt_nx;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]     r_idx, w_idx_nx;
  logic                 r_rb;
  logic [PAGE_BYTES-1:0] r_pg_vld;
  logic                 w_pg_fill, w_pg_wr;
  logic                 w_wen_rise, w_ren_rise, w_cmd, w_addr, w_data, w_busy;
  logic                 w_oe, w_prog_we, w_erase_we;
  logic [7:0]           w_rd_data, w_prog_byte;
  logic [ADDR_W-1:0]    w_prog_addr, w_erase_addr;

  // Array is held inverted so a zero power-up image reads back as erased FF.
  logic [7:0] r_mem_n    [DEPTH];
  logic [7:0] r_page_reg [PAGE_BYTES];

  function automatic logic is_busy(input state_t s);
    return (s == S_RD_BUSY) || (s == S_PG_BUSY) || (s == S_ER_BUSY) || (s == S_RST_BUSY);
  endfunction

  // Pin synchroniser stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen_q <= 1'b1;
      r_ren_q <= 1'b1;
      r_cle_q <= 1'b0;
      r_ale_q <= 1'b0;
      r_io_q  <= 8'h00;
    end else begin
      r_wen_q <= F_WEN;
      r_ren_q <= F_REN;
      r_cle_q <= F_CLE;
      r_ale_q <= F_ALE;
      r_io_q  <= F_IO;
    end
  end

  assign w_wen_rise = F_WEN & ~r_wen_q;
  assign w_ren_rise = F_REN & ~r_ren_q;
  assign w_cmd      = w_wen_rise & r_cle_q;
  assign w_addr     = w_wen_rise & ~r_cle_q & r_ale_q;
  assign w_data     = w_wen_rise & ~r_cle_q & ~r_ale_q;
  assign w_busy     = is_busy(r_state);

  always_comb begin
    w_state_nx   = r_state;
    w_half_nx    = r_half;
    w_col_nx     = r_col;
    w_col_ovf_nx = r_col_ovf;
    w_page_nx    = r_page;
    w_acnt_nx    = r_acnt;
    w_cnt_nx     = r_cnt;
    w_idx_nx     = r_idx;
    w_pg_fill    = 1'b0;
    w_pg_wr      = 1'b0;
    if (w_cmd && (r_io_q == 8'hFF)) begin
      w_state_nx = S_RST_BUSY;
      w_cnt_nx   = CNT_W'(T_RST - 1);
      w_half_nx  = 1'b0;
    end else if (w_busy) begin
      // Busy states ignore everything but reset; program/erase stream one byte per clk
      case (r_state)
        S_PG_BUSY: if (r_idx < IDX_W'(PAGE_BYTES)) w_idx_nx = r_idx + IDX_W'(1);
        S_ER_BUSY: if (r_idx < IDX_W'(BLOCK_BYTES)) w_idx_nx = r_idx + IDX_W'(1);
        default: ;
      endcase
      if (r_cnt == '0) begin
        case (r_state)
          S_RD_BUSY: begin w_state_nx = S_RD_DATA; w_half_nx = 1'b0; end
          S_PG_BUSY: begin w_state_nx = S_IDLE;    w_half_nx = 1'b0; end
          default:   w_state_nx = S_IDLE;
        endcase
      end else begin
        w_cnt_nx = r_cnt - CNT_W'(1);
      end
    end else if (w_cmd) begin
      w_acnt_nx = 2'd0;
      case (r_io_q)
        8'h00: begin w_half_nx = 1'b0; w_state_nx = S_RD_ADDR; end
        8'h01: begin w_half_nx = 1'b1; w_state_nx = S_RD_ADDR; end
        8'h80: begin w_pg_fill = 1'b1; w_state_nx = S_PG_ADDR; end
        8'h60: w_state_nx = S_ER_ADDR;
        8'h10: begin
          if (r_state == S_PG_DATA) begin
            w_state_nx = S_PG_BUSY;
            w_cnt_nx   = CNT_W'(T_PROG - 1);
            w_idx_nx   = '0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        8'hD0: begin
          if (r_state == S_ER_CONF) begin
            w_state_nx = S_ER_BUSY;
            w_cnt_nx   = CNT_W'(T_ERASE - 1);
            w_idx_nx   = '0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else if (w_addr) begin
      case (r_state)
        S_RD_ADDR, S_PG_ADDR: begin
          w_acnt_nx = r_acnt + 2'd1;
          case (r_acnt)
            2'd0: w_col_nx  = {r_half, r_io_q};
            2'd1: w_page_nx = PAGE_BITS'(r_io_q);
            default: begin
              w_page_nx = r_page | PAGE_BITS'({r_io_q[0], 8'h00});
              w_acnt_nx = 2'd0;
              if (r_state == S_RD_ADDR) begin
                w_state_nx = S_RD_BUSY;
                w_cnt_nx   = CNT_W'(T_R - 1);
              end else begin
                w_state_nx   = S_PG_DATA;
                w_col_ovf_nx = 1'b0;
              end
            end
          endcase
        end
        S_ER_ADDR: begin
          if (r_acnt == 2'd0) begin
            w_page_nx = PAGE_BITS'(r_io_q);
            w_acnt_nx = 2'd1;
          end else begin
            w_page_nx  = r_page | PAGE_BITS'({r_io_q[0], 8'h00});
            w_acnt_nx  = 2'd0;
            w_state_nx = S_ER_CONF;
          end
        end
        default: ;
      endcase
    end else if (w_data && (r_state == S_PG_DATA) && !r_col_ovf) begin
      w_pg_wr  = 1'b1;
      w_col_nx = r_col + COL_W'(1);
      if (r_col == '1) w_col_ovf_nx = 1'b1;
    end else if (w_ren_rise && (r_state == S_RD_DATA)) begin
      w_col_nx = r_col + COL_W'(1);
      if (r_col == '1) w_page_nx = r_page + PAGE_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_half    <= 1'b0;
      r_col     <= '0;
      r_col_ovf <= 1'b0;
      r_page    <= '0;
      r_acnt    <= 2'd0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rb      <= 1'b1;
      r_pg_vld  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_half    <= w_half_nx;
      r_col     <= w_col_nx;
      r_col_ovf <= w_col_ovf_nx;
      r_page    <= w_page_nx;
      r_acnt    <= w_acnt_nx;
      r_cnt     <= w_cnt_nx;
      r_idx     <= w_idx_nx;
      r_rb      <= ~is_busy(w_state_nx);
      // Unwritten page-register bytes read as FF, so clearing the mask is the fill
      if (w_pg_fill)    r_pg_vld        <= '0;
      else if (w_pg_wr) r_pg_vld[r_col] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pg_wr) r_page_reg[r_col] <= r_io_q;
  end

  assign w_prog_we    = (r_state == S_PG_BUSY) && (r_idx < IDX_W'(PAGE_BYTES));
  assign w_erase_we   = (r_state == S_ER_BUSY) && (r_idx < IDX_W'(BLOCK_BYTES));
  assign w_prog_addr  = {r_page, r_idx[8:0]};
  assign w_erase_addr = {r_page[PAGE_BITS-1:2], r_idx[10:0]};
  assign w_prog_byte  = r_pg_vld[r_idx[8:0]] ? r_page_reg[r_idx[8:0]] : 8'hFF;

  // Program can only clear bits (AND); erase sets the whole block back to FF
  always_ff @(posedge clk) begin
    if (w_prog_we)       r_mem_n[w_prog_addr]  <= r_mem_n[w_prog_addr] | ~w_prog_byte;
    else if (w_erase_we) r_mem_n[w_erase_addr] <= 8'h00;
  end

  assign w_rd_data = ~r_mem_n[{r_page, r_col}];
  assign w_oe      = ((r_state == S_RD_BUSY) || (r_state == S_RD_DATA)) & ~F_REN & ~F_CLE & ~F_ALE;
  assign F_IO      = w_oe ? w_rd_data : 8'hzz;
  assign F_RB      = r_rb;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: busy timing, program/read/erase
// contents, half-page selection, page wrap and reset during program.
module tb_nand_flash_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cle = 1'b0, ale = 1'b0, wen = 1'b1, ren = 1'b1;
  logic [7:0] tb_io = 8'h00;
  logic       tb_io_oe = 1'b0;
  logic       rb;
  wire  [7:0] F_IO;

  int n_pass = 0, n_total = 0;
  int run_len = 0, last_pulse = 0, pulse_cnt = 0, oe_cnt = 0;

  assign F_IO = tb_io_oe ? tb_io : 8'hzz;

  nand_flash_responder dut (
    .clk(clk), .rst(rst), .F_IO(F_IO), .F_CLE(cle), .F_ALE(ale),
    .F_WEN(wen), .F_REN(ren), .F_RB(rb)
  );

  always #5 clk = ~clk;

  // Measures each low pulse on F_RB and counts bus-drive cycles
  always @(negedge clk) begin
    if (!rb) begin
      run_len <= run_len + 1;
    end else if (run_len != 0) begin
      last_pulse <= run_len;
      pulse_cnt  <= pulse_cnt + 1;
      run_len    <= 0;
    end
    if (dut.w_oe) oe_cnt <= oe_cnt + 1;
  end

  typedef struct {
    string      name;
    logic [7:0] c, a0, a1, a2;
    int         n;
    logic [0:4][7:0] exp;
  } rvec_t;

  localparam int NV = 12;
  rvec_t vecs [NV];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_cycle(input logic c, input logic a, input logic [7:0] v);
    cle = c; ale = a; tb_io = v; tb_io_oe = 1'b1; wen = 1'b0;
    tick(2);
    wen = 1'b1;
    tick(2);
    cle = 1'b0; ale = 1'b0; tb_io_oe = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int exp_len);
    int n0;
    int k;
    n0 = pulse_cnt;
    k  = 0;
    while (rb !== 1'b1 && k < exp_len + 100) begin
      tick(1);
      k++;
    end
    tick(1);
    check({name, "_ready"}, 32'(rb), 32'd1);
    check({name, "_busy_len"}, (pulse_cnt == n0 + 1) ? 32'(last_pulse) : 32'hFFFF_FFFF, 32'(exp_len));
  endtask

  task automatic prog(input string name, input logic [7:0] hc, input logic [7:0] a0,
                      input logic [7:0] a1, input logic [7:0] a2, input int n,
                      input logic [0:3][7:0] d);
    bus_cycle(1'b1, 1'b0, hc);
    bus_cycle(1'b1, 1'b0, 8'h80);
    bus_cycle(1'b0, 1'b1, a0);
    bus_cycle(1'b0, 1'b1, a1);
    bus_cycle(1'b0, 1'b1, a2);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, d[i]);
    bus_cycle(1'b1, 1'b0, 8'h10);
    wait_busy(name, 600);
  endtask

  task automatic rd_open(input string name, input logic [7:0] c, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [7:0] a2);
    bus_cycle(1'b1, 1'b0, c);
    bus_cycle(1'b0, 1'b1, a0);
    bus_cycle(1'b0, 1'b1, a1);
    bus_cycle(1'b0, 1'b1, a2);
    wait_busy({name, "_rd"}, 16);
  endtask

  task automatic rd_byte(input string name, input logic [7:0] exp);
    ren = 1'b0;
    tick(1);
    check(name, 32'(F_IO), 32'(exp));
    ren = 1'b1;
    tick(2);
  endtask

  task automatic setv(input int i, input string nm, input logic [7:0] c, input logic [7:0] a0,
                      input logic [7:0] a1, input logic [7:0] a2, input int n,
                      input logic [0:4][7:0] e);
    vecs[i].name = nm; vecs[i].c = c; vecs[i].a0 = a0; vecs[i].a1 = a1;
    vecs[i].a2 = a2; vecs[i].n = n; vecs[i].exp = e;
  endtask

  initial begin
    int n0;
    setv(0,  "pg2_seq",     8'h00, 8'h00, 8'h02, 8'h00, 5, {8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF});
    setv(1,  "half1",       8'h01, 8'h10, 8'h05, 8'h01, 1, {8'hA5, 32'd0});
    setv(2,  "and_semant",  8'h00, 8'h05, 8'h03, 8'h00, 1, {8'h00, 32'd0});
    setv(3,  "erased_p4",   8'h00, 8'h07, 8'h04, 8'h00, 1, {8'hFF, 32'd0});
    setv(4,  "erased_p7",   8'h01, 8'hFF, 8'h07, 8'h00, 2, {8'hFF, 8'h88, 24'd0});
    setv(5,  "kept_p8",     8'h00, 8'h00, 8'h08, 8'h00, 1, {8'h88, 32'd0});
    setv(6,  "kept_p3",     8'h00, 8'h00, 8'h03, 8'h00, 1, {8'h3C, 32'd0});
    setv(7,  "page_wrap",   8'h01, 8'hFE, 8'h09, 8'h00, 4, {8'hE0, 8'hE1, 8'hA0, 8'hA1, 8'h00});
    setv(8,  "col_ovf_ign", 8'h00, 8'h00, 8'h09, 8'h00, 1, {8'hFF, 32'd0});
    setv(9,  "half_rd_clr", 8'h00, 8'h20, 8'h0B, 8'h00, 1, {8'h5C, 32'd0});
    setv(10, "half_rd_hi",  8'h01, 8'h20, 8'h0B, 8'h00, 1, {8'hFF, 32'd0});
    setv(11, "half_pg_clr", 8'h00, 8'h30, 8'h0D, 8'h00, 1, {8'h6D, 32'd0});

    tick(3);
    check("rst_rb", 32'(rb), 32'd1);
    check("rst_oe", 32'(dut.w_oe), 32'd0);
    rst = 1'b0;
    tick(2);
    check("post_rst_rb", 32'(rb), 32'd1);

    n0 = oe_cnt;
    bus_cycle(1'b1, 1'b0, 8'hFF);
    wait_busy("reset_cmd", 8);
    check("reset_no_drive", 32'(oe_cnt - n0), 32'd0);

    n0 = pulse_cnt;
    bus_cycle(1'b1, 1'b0, 8'hD0);
    tick(5);
    check("d0_ignored_rb", 32'(rb), 32'd1);
    check("d0_ignored_pulse", 32'(pulse_cnt - n0), 32'd0);

    prog("p2",    8'h00, 8'h00, 8'h02, 8'h00, 3, {8'h11, 8'h22, 8'h33, 8'h00});
    prog("p105",  8'h01, 8'h10, 8'h05, 8'h01, 1, {8'hA5, 24'd0});
    // No 00/01 prefix: half must have been cleared on leaving program busy
    bus_cycle(1'b1, 1'b0, 8'h80);
    bus_cycle(1'b0, 1'b1, 8'h30);
    bus_cycle(1'b0, 1'b1, 8'h0D);
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b0, 1'b0, 8'h6D);
    bus_cycle(1'b1, 1'b0, 8'h10);
    wait_busy("pD", 600);
    prog("and1",  8'h00, 8'h05, 8'h03, 8'h00, 1, {8'h0F, 24'd0});
    prog("and2",  8'h00, 8'h05, 8'h03, 8'h00, 1, {8'hF0, 24'd0});
    prog("p3",    8'h00, 8'h00, 8'h03, 8'h00, 1, {8'h3C, 24'd0});
    prog("p4",    8'h00, 8'h07, 8'h04, 8'h00, 1, {8'h44, 24'd0});
    prog("p7",    8'h01, 8'hFF, 8'h07, 8'h00, 1, {8'h77, 24'd0});
    prog("p8",    8'h00, 8'h00, 8'h08, 8'h00, 1, {8'h88, 24'd0});
    prog("p9",    8'h01, 8'hFE, 8'h09, 8'h00, 3, {8'hE0, 8'hE1, 8'hE2, 8'h00});
    prog("p10",   8'h00, 8'h00, 8'h0A, 8'h00, 2, {8'hA0, 8'hA1, 16'd0});

    bus_cycle(1'b1, 1'b0, 8'h60);
    bus_cycle(1'b0, 1'b1, 8'h04);
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b1, 1'b0, 8'hD0);
    wait_busy("erase", 2100);

    // A 01 read leaves half cleared once data phase is entered
    rd_open("hand", 8'h01, 8'h10, 8'h05, 8'h01);
    rd_byte("hand_a5", 8'hA5);
    bus_cycle(1'b1, 1'b0, 8'h80);
    bus_cycle(1'b0, 1'b1, 8'h20);
    bus_cycle(1'b0, 1'b1, 8'h0B);
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b0, 1'b0, 8'h5C);
    bus_cycle(1'b1, 1'b0, 8'h10);
    wait_busy("pB", 600);

    for (int i = 0; i < NV; i++) begin
      rd_open(vecs[i].name, vecs[i].c, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      for (int j = 0; j < vecs[i].n; j++)
        rd_byte($sformatf("%s[%0d]", vecs[i].name, j), vecs[i].exp[j]);
    end

    // Reset in the middle of a program busy period
    bus_cycle(1'b1, 1'b0, 8'h00);
    bus_cycle(1'b1, 1'b0, 8'h80);
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b0, 1'b1, 8'h0C);
    bus_cycle(1'b0, 1'b1, 8'h00);
    bus_cycle(1'b0, 1'b0, 8'h12);
    bus_cycle(1'b1, 1'b0, 8'h10);
    tick(50);
    check("pgbusy_rb_low", 32'(rb), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_rb", 32'(rb), 32'd1);
    tick(2);
    rst = 1'b0;
    tick(3);
    check("midrst_stays_ready", 32'(rb), 32'd1);
    rd_open("after_rst", 8'h00, 8'h00, 8'h0C, 8'h00);
    rd_byte("after_rst_byte", 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nand_flash_responder.md
# nand_flash_responder

Clocked model of the NAND flash device at the far end of the flash-controller pins. It decodes CLE/ALE/WEN/REN strobes, executes reset, page read, page program and block erase, drives read data onto the shared bus, and reports busy on F_RB. It serves as the device side for controller simulation and as a synthesizable flash stand-in on FPGA prototypes.

## Interface
- PAGE_BITS, 9, page address width; array = 2^(PAGE_BITS+9) bytes, 512 B/page, 4 pages/block
- T_R, 16, clk cycles F_RB held low after read address
- T_PROG, 600, busy cycles after program confirm (must be ≥ 512)
- T_ERASE, 2100, busy cycles after erase confirm (must be ≥ 2048)
- T_RST, 8, busy cycles after reset command
- clk  input  1  device clock, ≥ 2× controller strobe rate
- rst  input  1  reset rst, asynchronous, active-high; clock clk
- F_IO  inout  8  command/address/data bus; driven only during read data phase
- F_CLE  input  1  command latch enable
- F_ALE  input  1  address latch enable
- F_WEN  input  1  write strobe, active-low, latch on rising edge
- F_REN  input  1  read strobe, active-low
- F_RB  output  1  ready(1)/busy(0)

## Operation
- Input stage: F_WEN, F_REN, F_CLE, F_ALE, F_IO registered each clk (wen_q, ren_q, cle_q, ale_q, io_q). WEN rise = F_WEN & ~wen_q; REN rise likewise. On WEN rise: cle_q → command cycle, else ale_q → address cycle, else data cycle; value = io_q.
- States: IDLE, RD_ADDR, RD_BUSY, RD_DATA, PG_ADDR, PG_DATA, PG_BUSY, ER_ADDR, ER_CONF, ER_BUSY, RST_BUSY.
- Commands (accepted in any non-busy state; FF also in busy states): 00 → half=0, RD_ADDR; 01 → half=1, RD_ADDR; 80 → page register filled with FF, PG_ADDR (half keeps value from preceding 00/01); 10 in PG_DATA → PG_BUSY; 60 → ER_ADDR; D0 in ER_CONF → ER_BUSY; FF → RST_BUSY. Any other command or out-of-sequence command → IDLE, ignored.
- Read/program address: A0 → col[7:0], col[8]=half; A1 → page[7:0]; A2[0] → page[8]. Third address byte → RD_BUSY (read) or PG_DATA (program).
- Erase address: A0 → page[7:0]; A1[0] → page[8]; then ER_CONF. Block = page[PAGE_BITS-1:2].
- RD_DATA: F_IO driven with array[{page,col}] while F_REN=0 (combinational from pointer); REN rise → col+1; col 511 → col 0, page+1 (page wraps at max).
- PG_DATA: each data cycle writes page_reg[col] ← io_q, col+1; beyond 511 ignored.
- PG_BUSY: one byte per clk, array[{page,i}] ← array & page_reg[i] (i 0..511); remaining cycles idle to T_PROG.
- ER_BUSY: one byte per clk, 2048 bytes of block set to FF; pad to T_ERASE.
- half cleared to 0 on leaving PG_BUSY and on entering RD_DATA.
- FF during PG_BUSY/ER_BUSY aborts; bytes already written stay written.
- Array contents not affected by rst; initialised to all FF at time zero.

## Timing
- Reset values: F_RB=1, F_IO released (Z), state IDLE, half=0, col=0, page=0, busy counter 0.
- F_RB falls on the clk after the triggering WEN rise is detected (3rd read address, 10, D0, FF); stays low exactly T_R/T_PROG/T_ERASE/T_RST clks.
- WEN latency: byte sampled while WEN low is acted on 1 clk after WEN rise on pins.
- Read data valid whenever F_REN=0 in RD_DATA, including during RD_BUSY (data from array, not a buffer); REN-high to next byte: next col stable 2 clk after REN rise.
- F_IO output enable = (state RD_BUSY or RD_DATA) & ~F_REN & ~F_CLE & ~F_ALE.
- rst mid-operation: immediate return to reset values; in-flight program/erase truncated.

## Test plan
- Reset then FF command -> F_RB low for 8 clk then high; F_IO never driven.
- 80, addr 00/02/00, data 11,22,33, 10 -> F_RB low 600 clk; read 00, addr 00/02/00 -> bytes 11,22,33,FF,FF.
- 01, 80, addr 10/05/01, data A5, 10; read 01, addr 10/05/01 -> byte at index {9'h105,9'h110} = A5; half back to 0 afterwards.
- Program 0F then F0 to same byte without erase -> readback 00 (AND semantics).
- 60, addr 04/00, D0 -> F_RB low 2100 clk; pages 4..7 all FF, page 3 and 8 untouched.
- Read from col 510 with 4 REN pulses -> bytes page p col 510, 511, page p+1 col 0, 1; assert rst during PG_BUSY -> F_RB=1 immediately, state IDLE.
